fp_norm_round_pipe: RTL

- Parametrised, pipelined normalise-and-round stage for the FP adder datapath.
- Takes the un-normalised sum, exponent, sign and special-case flags from the align/add stage.
- Produces an IEEE-754 packed result plus exception flags, two cycles later.
- Generalises the combinational half-precision normaliser: any exponent/fraction width, valid/ready flow control, true sticky tracking, denormal-to-normal round carry, and status flags.

---
 rtl/fp_norm_round_pipe_if.sv | 30 +++
 rtl/fp_norm_round_pipe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round_pipe_if.sv
// Handshake and datapath bundle between the FP align/add stage, the
// normalise-and-round pipe, and its downstream consumer.
interface fp_norm_round_pipe_if #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               rm;
  logic                     sign;
  logic                     is_nan;
  logic                     is_inf;
  logic [FRAC_W-1:0]        inf_nan_frac;
  logic [EXP_W-1:0]         temp_exp;
  logic [FRAC_W+4:0]        cal_frac;
  logic                     out_valid;
  logic                     out_ready;
  logic [EXP_W+FRAC_W:0]    s;
  logic [2:0]               flags;

  modport master (
    output in_valid, rm, sign, is_nan, is_inf, inf_nan_frac, temp_exp, cal_frac, out_ready,
    input  in_ready, out_valid, s, flags
  );

  modport slave (
    input  in_valid, rm, sign, is_nan, is_inf, inf_nan_frac, temp_exp, cal_frac, out_ready,
    output in_ready, out_valid, s, flags
  );
endinterface

// File: rtl/fp_norm_round_pipe.sv
// Two-stage FP normalise (LZC + shift) and round pipe with valid/ready flow
// control; emits the packed IEEE-754 result and {overflow, underflow, inexact}.
module fp_norm_round_pipe #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10,
  parameter int LZC_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_norm_round_pipe_if.slave  io
);
  localparam int LZ_N = 1 << LZC_W;
  localparam int W    = 1 + EXP_W + FRAC_W;
  localparam int XW   = EXP_W + LZC_W;
  localparam logic [LZC_W-1:0] LZ_NONE     = LZC_W'(FRAC_W + 2);
  localparam logic [EXP_W-1:0] EXP_MAX     = '1;
  localparam logic [EXP_W-1:0] EXP_MAX_FIN = EXP_W'((1 << EXP_W) - 2);

  logic en;

  logic                 v1_q;
  logic [FRAC_W+3:0]    frac0_q, frac0_d;
  logic [EXP_W-1:0]     exp0_q, exp0_d;
  logic                 sign_q, nan_q, inf_q;
  logic [1:0]           rm_q;
  logic [FRAC_W-1:0]    infn_q;

  logic                 v2_q;
  logic [W-1:0]         s_q, s_d;
  logic [2:0]           flags_q, flags_d;

  logic [LZ_N-1:0]      lz_tmp;
  logic [LZC_W-1:0]     lz;
  logic [FRAC_W+3:0]    body;
  logic [EXP_W:0]       exp_inc;
  logic [EXP_W-1:0]     dn_sh;

  assign en           = ~v2_q | io.out_ready;
  assign io.in_ready  = en;
  assign io.out_valid = v2_q;
  assign io.s         = s_q;
  assign io.flags     = flags_q;

  // Counted span is hidden..guard; padding ones below cap an all-zero span at FRAC_W+2.
  always_comb begin
    lz_tmp = '1;
    lz_tmp[LZ_N-1 -: FRAC_W+2] = io.cal_frac[FRAC_W+3:2];
    lz = '0;
    for (int k = LZC_W - 1; k >= 0; k--) begin
      if ((lz_tmp >> (LZ_N - (1 << k))) == '0) begin
        lz[k]  = 1'b1;
        lz_tmp = lz_tmp << (1 << k);
      end
    end
  end

  always_comb begin
    body    = io.cal_frac[FRAC_W+3:0];
    exp_inc = {1'b0, io.temp_exp} + (EXP_W+1)'(1);
    dn_sh   = io.temp_exp - EXP_W'(1);
    frac0_d = body;
    exp0_d  = '0;
    if (io.cal_frac[FRAC_W+4]) begin
      frac0_d = {io.cal_frac[FRAC_W+4:2], |io.cal_frac[1:0]};
      exp0_d  = exp_inc[EXP_W] ? EXP_MAX : exp_inc[EXP_W-1:0];
    end else if ((XW'(io.temp_exp) > XW'(lz)) && (lz != LZ_NONE)) begin
      frac0_d = body << lz;
      exp0_d  = EXP_W'(XW'(io.temp_exp) - XW'(lz));
    end else if (io.temp_exp != '0) begin
      frac0_d = body << dn_sh;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      frac0_q <= '0;
      exp0_q  <= '0;
      sign_q  <= 1'b0;
      nan_q   <= 1'b0;
      inf_q   <= 1'b0;
      rm_q    <= 2'b00;
      infn_q  <= '0;
    end else if (en) begin
      v1_q <= io.in_valid;
      if (io.in_valid) begin
        frac0_q <= frac0_d;
        exp0_q  <= exp0_d;
        sign_q  <= io.sign;
        nan_q   <= io.is_nan;
        inf_q   <= io.is_inf;
        rm_q    <= io.rm;
        infn_q  <= io.inf_nan_frac;
      end
    end
  end

  logic [2:0]        grs;
  logic              rnd_inc;
  logic [FRAC_W+1:0] frac_rnd;
  logic [EXP_W:0]    exp_r;
  logic [FRAC_W-1:0] frac_r;
  logic              ovf;
  logic              inexact;
  logic [W-1:0]      res_inf, res_max;

  always_comb begin
    grs = frac0_q[2:0];
    unique case (rm_q)
      2'b00:   rnd_inc = grs[2] & (grs[1] | grs[0] | frac0_q[3]);
      2'b01:   rnd_inc = (|grs) & sign_q;
      2'b10:   rnd_inc = (|grs) & ~sign_q;
      default: rnd_inc = 1'b0;
    endcase
    frac_rnd = {1'b0, frac0_q[FRAC_W+3:3]} + (FRAC_W+2)'(rnd_inc);
    frac_r   = frac_rnd[FRAC_W-1:0];
    exp_r    = {1'b0, exp0_q};
    if (frac_rnd[FRAC_W+1]) begin
      exp_r  = {1'b0, exp0_q} + (EXP_W+1)'(1);
      frac_r = '0;
    end else if ((exp0_q == '0) && frac_rnd[FRAC_W]) begin
      exp_r  = (EXP_W+1)'(1);
    end
    ovf     = (exp0_q == EXP_MAX) | (exp_r >= {1'b0, EXP_MAX});
    inexact = (|grs) | ovf;
    res_inf = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
    res_max = {sign_q, EXP_MAX_FIN, {FRAC_W{1'b1}}};

    s_d     = {sign_q, exp_r[EXP_W-1:0], frac_r};
    flags_d = {1'b0, inexact & (exp_r[EXP_W-1:0] == '0), inexact};
    if (nan_q) begin
      s_d     = {1'b1, EXP_MAX, infn_q};
      flags_d = 3'b000;
    end else if (inf_q) begin
      s_d     = {sign_q, EXP_MAX, infn_q};
      flags_d = 3'b000;
    end else if (ovf) begin
      flags_d = 3'b101;
      unique case (rm_q)
        2'b00:   s_d = res_inf;
        2'b01:   s_d = sign_q ? res_inf : res_max;
        2'b10:   s_d = sign_q ? res_max : res_inf;
        default: s_d = res_max;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q    <= 1'b0;
      s_q     <= '0;
      flags_q <= 3'b000;
    end else if (en) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s_q     <= s_d;
        flags_q <= flags_d;
      end
    end
  end
endmodule
